// File: rtl/priority_encoder_hs_if.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder_hs_if
// Purpose  : Bundle of request, selection and grant-handshake signals that
//            connect the priority encoder to its producer and consumer.
// Signals  : req       - level request lines (producer -> encoder)
//            mask      - per-line eligibility (producer -> encoder)
//            mode      - 0 fixed priority, 1 round-robin
//            out_valid - grant present (encoder -> consumer)
//            out_idx   - granted index (encoder -> consumer)
//            out_ready - consumer accepts the grant
//            pending_o - sticky pending status (encoder -> observer)
// Modports : master - the encoder side; slave - the environment side
// Revision : 1.0 - initial release
// ============================================================================
interface priority_encoder_hs_if #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
);
    logic [N-1:0]     req;
    logic [N-1:0]     mask;
    logic             mode;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready;
    logic [N-1:0]     pending_o;

    modport master (
        input  req, mask, mode, out_ready,
        output out_valid, out_idx, pending_o
    );

    modport slave (
        output req, mask, mode, out_ready,
        input  out_valid, out_idx, pending_o
    );
endinterface
`default_nettype wire

// File: rtl/priority_encoder_hs.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder_hs
// Purpose  : Registered priority encoder with sticky request latching and a
//            valid/ready grant handshake. Fixed (MSB-highest) or round-robin
//            selection, chosen at run time.
// Ports    : clk - rising-edge clock
//            rst - asynchronous active-high reset
//            bus - priority_encoder_hs_if.master (req, mask, mode, out_ready
//                  in; out_valid, out_idx, pending_o out)
// Revision : 1.0 - initial release
// ============================================================================
module priority_encoder_hs #(
    parameter int N = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    priority_encoder_hs_if.master bus
);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_pending;
    logic [IDX_W-1:0] r_out_idx;
    logic [IDX_W-1:0] r_rr_ptr;

    logic [N-1:0]     w_eligible;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_pending_next;
    logic             w_found;
    logic [IDX_W-1:0] w_fix_idx;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W-1:0] w_winner;
    logic             w_load;
    logic             w_accept;

    // Selection looks only at the registered pending bits, never at this
    // cycle's raw requests.
    assign w_eligible = r_pending & bus.mask;
    assign w_found    = |w_eligible;

    // Winner search. Both loops let the last hit win, so each is ordered from
    // lowest to highest priority.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] pos_idx;
        w_fix_idx = '0;
        w_rr_idx  = '0;
        pos       = 0;
        pos_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (w_eligible[i]) begin
                w_fix_idx = IDX_W'(i);
            end
        end
        // Distance k=0 is (rr_ptr-1) mod N (highest), k=N-1 is rr_ptr itself
        // (lowest). The sum never exceeds 2N-2, so one wrap is enough.
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(r_rr_ptr) + N - 1 - k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDX_W'(pos);
            if (w_eligible[pos_idx]) begin
                w_rr_idx = pos_idx;
            end
        end
    end

    assign w_winner = bus.mode ? w_rr_idx : w_fix_idx;

    // Next-state and control.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_load       = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A request on the bit being cleared wins because req is ORed last.
    assign w_clr          = w_accept ? ({{(N-1){1'b0}}, 1'b1} << r_out_idx) : '0;
    assign w_pending_next = (r_pending & ~w_clr) | bus.req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_out_idx <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (w_load) begin
                r_out_idx <= w_winner;
            end
            // Pointer tracks the last accepted index in both modes.
            if (w_accept) begin
                r_rr_ptr <= r_out_idx;
            end
        end
    end

    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_idx   = r_out_idx;
    assign bus.pending_o = r_pending;
endmodule
`default_nettype wire
